// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional even/odd parity, 1 or 2 stop bits,
// 3-sample majority voting, error/break reporting and a ready/valid output handshake.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 108,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 uart_clock,
  input  logic                 uart_reset,
  input  logic                 uart_d_in,
  output logic [DATA_BITS-1:0] uart_d_out,
  output logic                 uart_valid,
  input  logic                 uart_ready,
  output logic                 uart_frame_err,
  output logic                 uart_parity_err,
  output logic                 uart_overrun,
  output logic                 uart_break,
  output logic                 uart_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_MID  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] C_MM1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_MP1  = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_EN    = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 2);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAIT_IDLE
  } state_t;

  state_t               state_reg;
  logic [1:0]           sync_reg;
  logic [CW-1:0]        cnt_reg;
  logic [BW-1:0]        bit_idx_reg;
  logic                 stop_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 s0_reg, s1_reg;
  logic                 fe_reg, pe_reg, zero_reg;

  logic rx_s, maj, at_mp1, end_bit, par_exp;

  assign rx_s    = sync_reg[1];
  assign maj     = (s0_reg & s1_reg) | (s0_reg & rx_s) | (s1_reg & rx_s);
  assign at_mp1  = (cnt_reg == C_MP1);
  assign end_bit = (cnt_reg == C_LAST);
  assign par_exp = (^shift_reg) ^ PAR_ODD;
  assign uart_busy = (state_reg != S_IDLE);

  always_ff @(posedge uart_clock or posedge uart_reset) begin
    if (uart_reset) begin
      state_reg       <= S_IDLE;
      sync_reg        <= 2'b11;
      cnt_reg         <= '0;
      bit_idx_reg     <= '0;
      stop_idx_reg    <= 1'b0;
      shift_reg       <= '0;
      s0_reg          <= 1'b1;
      s1_reg          <= 1'b1;
      fe_reg          <= 1'b0;
      pe_reg          <= 1'b0;
      zero_reg        <= 1'b0;
      uart_d_out      <= '0;
      uart_valid      <= 1'b0;
      uart_frame_err  <= 1'b0;
      uart_parity_err <= 1'b0;
      uart_overrun    <= 1'b0;
      uart_break      <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[0], uart_d_in};
      uart_overrun <= 1'b0;
      uart_break   <= 1'b0;
      if (uart_valid && uart_ready) uart_valid <= 1'b0;
      if (cnt_reg == C_MM1) s0_reg <= rx_s;
      if (cnt_reg == C_MID) s1_reg <= rx_s;

      case (state_reg)
        S_IDLE: begin
          cnt_reg <= '0;
          if (!rx_s) begin
            state_reg    <= S_START;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            fe_reg       <= 1'b0;
            pe_reg       <= 1'b0;
            zero_reg     <= 1'b1;
          end
        end
        S_START: begin
          cnt_reg <= end_bit ? '0 : cnt_reg + 1'b1;
          if (at_mp1 && maj) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
          end else if (end_bit) begin
            state_reg <= S_DATA;
          end
        end
        S_DATA: begin
          cnt_reg <= end_bit ? '0 : cnt_reg + 1'b1;
          if (at_mp1) begin
            shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
            zero_reg  <= zero_reg & ~maj;
          end
          if (end_bit) begin
            if (bit_idx_reg == B_LAST) state_reg <= PAR_EN ? S_PARITY : S_STOP;
            else bit_idx_reg <= bit_idx_reg + 1'b1;
          end
        end
        S_PARITY: begin
          cnt_reg <= end_bit ? '0 : cnt_reg + 1'b1;
          if (at_mp1) begin
            pe_reg   <= (maj != par_exp);
            zero_reg <= zero_reg & ~maj;
          end
          if (end_bit) state_reg <= S_STOP;
        end
        S_STOP: begin
          cnt_reg <= end_bit ? '0 : cnt_reg + 1'b1;
          if (at_mp1) begin
            if (!maj) fe_reg <= 1'b1;
            if (!stop_idx_reg) zero_reg <= zero_reg & ~maj;
            // Leave mid-bit so a start bit right after the stop bit is not missed.
            if (stop_idx_reg == STOP_LAST) begin
              state_reg <= S_DONE;
              cnt_reg   <= '0;
            end
          end
          if (end_bit) stop_idx_reg <= 1'b1;
        end
        S_DONE: begin
          cnt_reg <= '0;
          if (zero_reg) begin
            uart_break <= 1'b1;
            state_reg  <= S_WAIT_IDLE;
          end else begin
            if (!uart_valid || uart_ready) begin
              uart_d_out      <= shift_reg;
              uart_frame_err  <= fe_reg;
              uart_parity_err <= pe_reg;
              uart_valid      <= 1'b1;
            end else begin
              uart_overrun <= 1'b1;
            end
            state_reg <= fe_reg ? S_WAIT_IDLE : S_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          // Re-synchronise: require a full bit time of continuous idle line.
          if (!rx_s) cnt_reg <= '0;
          else if (end_bit) begin
            cnt_reg   <= '0;
            state_reg <= S_IDLE;
          end else cnt_reg <= cnt_reg + 1'b1;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1 instance plus even- and odd-parity instances on a shared line.
module tb_uart_rx_cfg;
  localparam int CPB = 108;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic rx_a = 1'b1, rx_p = 1'b1, rdy_a = 1'b1, rdy_p = 1'b1;
  logic [7:0] d_a, d_e, d_o;
  logic valid_a, fe_a, pe_a, ovr_a, brk_a, busy_a;
  logic valid_e, fe_e, pe_e, ovr_e, brk_e, busy_e;
  logic valid_o, fe_o, pe_o, ovr_o, brk_o, busy_o;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB)) dut_a (
    .uart_clock(clk), .uart_reset(rst), .uart_d_in(rx_a), .uart_d_out(d_a),
    .uart_valid(valid_a), .uart_ready(rdy_a), .uart_frame_err(fe_a),
    .uart_parity_err(pe_a), .uart_overrun(ovr_a), .uart_break(brk_a), .uart_busy(busy_a));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .PARITY(1)) dut_e (
    .uart_clock(clk), .uart_reset(rst), .uart_d_in(rx_p), .uart_d_out(d_e),
    .uart_valid(valid_e), .uart_ready(rdy_p), .uart_frame_err(fe_e),
    .uart_parity_err(pe_e), .uart_overrun(ovr_e), .uart_break(brk_e), .uart_busy(busy_e));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut_o (
    .uart_clock(clk), .uart_reset(rst), .uart_d_in(rx_p), .uart_d_out(d_o),
    .uart_valid(valid_o), .uart_ready(rdy_p), .uart_frame_err(fe_o),
    .uart_parity_err(pe_o), .uart_overrun(ovr_o), .uart_break(brk_o), .uart_busy(busy_o));

  int tests = 0, fails = 0;
  int ovr_cnt = 0, brk_cnt = 0;
  logic [9:0] q_a[$], q_e[$], q_o[$];   // {data, frame_err, parity_err}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // bits[0] goes on the line first; glitch_at inverts one cycle of the frame.
  task automatic send(input bit sel_p, input logic [11:0] bits, input int n, input int glitch_at);
    logic v;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CPB; c++) begin
        v = bits[i];
        if (i * CPB + c == glitch_at) v = ~v;
        if (sel_p) rx_p = v;
        else rx_a = v;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic frame_a(input logic [7:0] d, input logic stop);
    send(1'b0, {2'b00, stop, d, 1'b0}, 10, -1);
  endtask

  task automatic frame_p(input logic [7:0] d, input logic par);
    send(1'b1, {1'b0, 1'b1, par, d, 1'b0}, 11, -1);
  endtask

  task automatic wait_drain(input int max_cycles);
    int k;
    k = 0;
    while ((q_a.size() + q_e.size() + q_o.size()) != 0 && k < max_cycles) begin
      tick(1);
      k++;
    end
    chk("drain_pending", 32'(q_a.size() + q_e.size() + q_o.size()), 32'd0);
  endtask

  // Scoreboard monitors: one pop per accepted word.
  always @(negedge clk) begin : mon_a
    logic [9:0] e;
    if (ovr_a) ovr_cnt++;
    if (brk_a) brk_cnt++;
    if (!rst && valid_a && rdy_a) begin
      tests++;
      assert (q_a.size() > 0) else begin
        fails++;
        $error("FAIL a_spurious_valid observed=%0h expected=none", d_a);
      end
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a_word", 32'({d_a, fe_a, pe_a}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_e
    logic [9:0] e;
    if (!rst && valid_e && rdy_p) begin
      tests++;
      assert (q_e.size() > 0) else begin
        fails++;
        $error("FAIL e_spurious_valid observed=%0h expected=none", d_e);
      end
      if (q_e.size() > 0) begin
        e = q_e.pop_front();
        chk("e_word", 32'({d_e, fe_e, pe_e}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_o
    logic [9:0] e;
    if (!rst && valid_o && rdy_p) begin
      tests++;
      assert (q_o.size() > 0) else begin
        fails++;
        $error("FAIL o_spurious_valid observed=%0h expected=none", d_o);
      end
      if (q_o.size() > 0) begin
        e = q_o.pop_front();
        chk("o_word", 32'({d_o, fe_o, pe_o}), 32'(e));
      end
    end
  end

  initial begin
    logic [7:0] eled [4];
    eled = '{8'h45, 8'h4C, 8'h45, 8'h44};

    // Reset state
    rst = 1'b1;
    tick(5);
    chk("rst_d_out", 32'(d_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_flags", 32'({fe_a, pe_a, ovr_a, brk_a}), 32'd0);
    chk("rst_par_valid", 32'({valid_e, valid_o}), 32'd0);
    rst = 1'b0;
    tick(20);

    // 8N1 "ELED" with 100 us gaps
    foreach (eled[i]) begin
      q_a.push_back({eled[i], 2'b00});
      frame_a(eled[i], 1'b1);
      tick(5000);
    end
    wait_drain(2000);

    // Parity: 0x45 has odd popcount, so even parity bit = 1
    q_e.push_back({8'h45, 2'b00});
    q_o.push_back({8'h45, 2'b01});
    frame_p(8'h45, 1'b1);
    tick(300);
    q_e.push_back({8'h45, 2'b01});
    q_o.push_back({8'h45, 2'b00});
    frame_p(8'h45, 1'b0);
    tick(300);
    wait_drain(2000);

    // Framing error, immediate follower ignored, later frame clean
    q_a.push_back({8'h41, 2'b10});
    frame_a(8'h41, 1'b0);
    frame_a(8'h00, 1'b1);
    tick(300);
    wait_drain(2000);
    chk("fe_resync_idle", 32'(busy_a), 32'd0);
    q_a.push_back({8'h42, 2'b00});
    frame_a(8'h42, 1'b1);
    tick(300);
    wait_drain(2000);

    // Overrun with consumer stalled
    rdy_a   = 1'b0;
    ovr_cnt = 0;
    q_a.push_back({8'h11, 2'b00});
    frame_a(8'h11, 1'b1);
    frame_a(8'h22, 1'b1);
    tick(300);
    chk("ovr_pulse_cycles", 32'(ovr_cnt), 32'd1);
    chk("ovr_hold_data", 32'(d_a), 32'h11);
    chk("ovr_hold_valid", 32'(valid_a), 32'd1);
    rdy_a = 1'b1;
    tick(1);
    rdy_a = 1'b0;
    tick(2);
    chk("ovr_valid_drop", 32'(valid_a), 32'd0);
    chk("ovr_queue_empty", 32'(q_a.size()), 32'd0);
    rdy_a = 1'b1;

    // False start and mid-bit glitch
    rx_a = 1'b0;
    tick(30);
    rx_a = 1'b1;
    tick(300);
    chk("false_start_idle", 32'(busy_a), 32'd0);
    q_a.push_back({8'h55, 2'b00});
    send(1'b0, {2'b00, 1'b1, 8'h55, 1'b0}, 10, 4 * CPB + CPB / 2);
    tick(300);
    wait_drain(2000);

    // Break: line low for 20 bit times
    brk_cnt = 0;
    rx_a = 1'b0;
    tick(20 * CPB);
    rx_a = 1'b1;
    tick(400);
    chk("break_pulse_cycles", 32'(brk_cnt), 32'd1);
    chk("break_no_valid", 32'(valid_a), 32'd0);
    chk("break_idle", 32'(busy_a), 32'd0);

    // Reset mid-frame clears outputs immediately
    send(1'b0, {2'b00, 1'b1, 8'h45, 1'b0}, 5, -1);
    chk("mid_frame_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", 32'({valid_a, busy_a, fe_a, pe_a, ovr_a, brk_a}), 32'd0);
    chk("mid_rst_d_out", 32'(d_a), 32'd0);
    rx_a = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(200);
    q_a.push_back({8'h45, 2'b00});
    frame_a(8'h45, 1'b1);
    tick(300);
    wait_drain(2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
